// File: rtl/rf_sort_sequencer.sv
// Register-file sort sequencer: loads a block of registers into a local buffer,
// bubble-sorts it one compare-and-swap per cycle, and writes it back to a destination block.
module rf_sort_sequencer #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              descending,
    input  logic [AW-1:0]     src_base,
    input  logic [AW-1:0]     dst_base,
    input  logic [CW-1:0]     count,
    output logic [AW-1:0]     rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic [AW-1:0]     rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_enable,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, LOAD, SORT, STORE, DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] buf_q [DEPTH];
    logic [AW-1:0]     k_q, i_q, j_q, j_nx;
    logic [AW-1:0]     src_q, dst_q;
    logic [CW-1:0]     cnt_q;
    logic              desc_q, err_q;
    logic              count_ok, last_k, last_i, last_j, swap;
    logic [DATA_W-1:0] lo_v, hi_v;

    assign count_ok = (count != '0) && (count <= CW'(DEPTH));
    assign j_nx     = j_q + AW'(1);
    assign lo_v     = buf_q[j_q];
    assign hi_v     = buf_q[j_nx];
    assign swap     = desc_q ? (lo_v < hi_v) : (lo_v > hi_v);

    // Pass i covers j = 0 .. cnt-2-i; the final pass is i = cnt-2.
    assign last_k = ({1'b0, k_q} == cnt_q - CW'(1));
    assign last_i = ({1'b0, i_q} == cnt_q - CW'(2));
    assign last_j = ({1'b0, j_q} == cnt_q - CW'(2) - {1'b0, i_q});
    assign err    = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            k_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        desc_q <= descending;
                        src_q  <= src_base;
                        dst_q  <= dst_base;
                        cnt_q  <= count;
                        err_q  <= !count_ok;
                        k_q    <= '0;
                        i_q    <= '0;
                        j_q    <= '0;
                    end
                end
                LOAD:  k_q <= last_k ? '0 : k_q + AW'(1);
                SORT: begin
                    if (last_j) begin
                        j_q <= '0;
                        i_q <= i_q + AW'(1);
                    end else begin
                        j_q <= j_nx;
                    end
                end
                STORE: k_q <= k_q + AW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == LOAD) begin
            buf_q[k_q] <= rf_read_data;
        end else if (state_q == SORT && swap) begin
            buf_q[j_q]  <= hi_v;
            buf_q[j_nx] <= lo_v;
        end
    end

    always_comb begin
        state_d         = state_q;
        rf_read_addr    = '0;
        rf_write_addr   = '0;
        rf_write_data   = '0;
        rf_write_enable = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = count_ok ? LOAD : DONE;
            end
            LOAD: begin
                busy         = 1'b1;
                rf_read_addr = src_q + k_q;
                if (last_k) state_d = (cnt_q == CW'(1)) ? STORE : SORT;
            end
            SORT: begin
                busy = 1'b1;
                if (last_j && last_i) state_d = STORE;
            end
            STORE: begin
                busy            = 1'b1;
                rf_write_enable = 1'b1;
                rf_write_addr   = dst_q + k_q;
                rf_write_data   = buf_q[k_q];
                if (last_k) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rf_sort_sequencer.sv
// Scoreboard bench for rf_sort_sequencer: a counting-sort reference predicts the
// write stream, done timing, err flag and final register-file image.
module tb_rf_sort_sequencer;

    localparam int DW  = 4;
    localparam int DEP = 8;

    logic          clk = 1'b0;
    logic          reset, start, descending;
    logic [2:0]    src_base, dst_base, rf_read_addr, rf_write_addr;
    logic [3:0]    count;
    logic [DW-1:0] rf_read_data, rf_write_data;
    logic          rf_write_enable, busy, done, err;

    logic [DW-1:0] rf      [DEP];
    logic [DW-1:0] rf_init [DEP];
    logic          load_all;

    typedef struct { logic [2:0] a; logic [DW-1:0] d; } wr_t;
    typedef struct { int cyc; logic e; } dn_t;
    wr_t wq[$];
    dn_t dq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    rf_sort_sequencer #(.DATA_W(DW), .DEPTH(DEP)) dut (
        .clk(clk), .reset(reset), .start(start), .descending(descending),
        .src_base(src_base), .dst_base(dst_base), .count(count),
        .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .rf_write_enable(rf_write_enable), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rf_read_data = rf[rf_read_addr];
    always @(posedge clk) begin
        if (rf_write_enable) rf[rf_write_addr] <= rf_write_data;
        else if (load_all)   rf <= rf_init;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: every write and every done pulse must match the scoreboard head.
    wr_t w;
    dn_t dn;
    always @(negedge clk) begin
        if (rf_write_enable) begin
            if (wq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write got=addr%0d/data%0d exp=none", rf_write_addr, rf_write_data);
            end else begin
                w = wq.pop_front();
                chk("wr_addr", 32'(rf_write_addr), 32'(w.a));
                chk("wr_data", 32'(rf_write_data), 32'(w.d));
            end
        end
        if (done) begin
            if (dq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done got=1 exp=0 cyc=%0d", cyc);
            end else begin
                dn = dq.pop_front();
                chk("done_cycle", 32'(cyc), 32'(dn.cyc));
                chk("done_err", 32'(err), 32'(dn.e));
            end
        end
    end

    task automatic load_rf();
        @(negedge clk) load_all = 1'b1;
        @(negedge clk) load_all = 1'b0;
    endtask

    task automatic rand_init();
        for (int i = 0; i < DEP; i++) rf_init[i] = DW'($urandom);
    endtask

    task automatic check_idle_outputs(input logic exp_err);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_we",   32'(rf_write_enable), 0);
        chk("idle_ra",   32'(rf_read_addr), 0);
        chk("idle_wa",   32'(rf_write_addr), 0);
        chk("idle_wd",   32'(rf_write_data), 0);
        chk("idle_err",  32'(err), 32'(exp_err));
    endtask

    // Issue one sort and wait for its done pulse; called from a negedge with the DUT idle.
    task automatic run_job(input int c, input int s, input int d, input bit desc, input bit noise);
        logic [DW-1:0] snap [DEP];
        logic [DW-1:0] expm [DEP];
        logic [DW-1:0] srt[$];
        int  hist [1<<DW];
        int  lat, e0;
        bit  legal, got_done;

        snap  = rf;
        expm  = rf;
        legal = (c >= 1) && (c <= DEP);
        if (legal) begin
            for (int v = 0; v < (1<<DW); v++) hist[v] = 0;
            for (int k = 0; k < c; k++) hist[snap[(s + k) % DEP]]++;
            srt = {};
            for (int n = 0; n < (1<<DW); n++) begin
                int v;
                v = desc ? ((1<<DW) - 1 - n) : n;
                for (int r = 0; r < hist[v]; r++) srt.push_back(DW'(v));
            end
            for (int k = 0; k < c; k++) begin
                expm[(d + k) % DEP] = srt[k];
                wq.push_back('{a: 3'((d + k) % DEP), d: srt[k]});
            end
            lat = 2*c + c*(c-1)/2 + 1;
        end else begin
            lat = 1;
        end

        start = 1'b1; descending = desc;
        src_base = 3'(s); dst_base = 3'(d); count = 4'(c);
        @(posedge clk);
        #1;
        e0 = cyc;
        dq.push_back('{cyc: e0 + lat - 1, e: !legal});
        start = 1'b0;

        got_done = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                break;
            end
            chk("busy_run", 32'(busy), 1);
            if (noise) begin
                start      = ($urandom % 3) == 0;
                descending = 1'($urandom);
                src_base   = 3'($urandom);
                dst_base   = 3'($urandom);
                count      = 4'($urandom);
            end
        end
        if (!got_done) begin
            total++; bad++;
            $display("FAIL done_timeout got=no_done exp=done_after_%0d_edges", lat);
        end
        chk("busy_done", 32'(busy), 0);
        if (noise) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_idle_outputs(!legal);
        chk("wq_empty", 32'(wq.size()), 0);
        for (int i = 0; i < DEP; i++) chk($sformatf("mem%0d", i), 32'(rf[i]), 32'(expm[i]));
    endtask

    task automatic reset_abort_test();
        logic [DW-1:0] snap [DEP];
        rand_init();
        load_rf();
        snap  = rf;
        start = 1'b1; descending = 1'b0; src_base = 3'd0; dst_base = 3'd0; count = 4'd8;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8 + 5) @(negedge clk);
        chk("busy_in_sort", 32'(busy), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err",  32'(err), 0);
        chk("rst_we",   32'(rf_write_enable), 0);
        chk("rst_ra",   32'(rf_read_addr), 0);
        chk("rst_wa",   32'(rf_write_addr), 0);
        chk("rst_wd",   32'(rf_write_data), 0);
        @(negedge clk) reset = 1'b0;
        repeat (40) @(negedge clk);
        for (int i = 0; i < DEP; i++) chk($sformatf("abort_mem%0d", i), 32'(rf[i]), 32'(snap[i]));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; descending = 1'b0;
        src_base = '0; dst_base = '0; count = '0; load_all = 1'b0;
        for (int i = 0; i < DEP; i++) rf_init[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_busy", 32'(busy), 0);
        chk("init_done", 32'(done), 0);
        chk("init_err",  32'(err), 0);
        chk("init_we",   32'(rf_write_enable), 0);
        chk("init_ra",   32'(rf_read_addr), 0);
        chk("init_wa",   32'(rf_write_addr), 0);
        chk("init_wd",   32'(rf_write_data), 0);
        load_rf();
        @(negedge clk) reset = 1'b0;
        @(negedge clk);

        rand_init();
        rf_init[0] = 4'd9; rf_init[1] = 4'd2; rf_init[2] = 4'd7; rf_init[3] = 4'd2;
        load_rf();
        run_job(4, 0, 4, 1'b0, 1'b0);

        load_rf();
        run_job(4, 0, 0, 1'b1, 1'b0);

        rand_init();
        rf_init[6] = 4'd3; rf_init[7] = 4'd1; rf_init[0] = 4'd4; rf_init[1] = 4'd0;
        load_rf();
        run_job(4, 6, 6, 1'b0, 1'b0);

        run_job(0, 1, 3, 1'b0, 1'b0);
        run_job(9, 2, 4, 1'b1, 1'b0);
        run_job(3, 1, 5, 1'b0, 1'b0);

        reset_abort_test();
        run_job(8, 3, 3, 1'b0, 1'b0);

        rand_init();
        rf_init[2] = 4'hA;
        load_rf();
        run_job(1, 2, 5, 1'b0, 1'b1);

        for (int t = 0; t < 40; t++) begin
            int c;
            rand_init();
            load_rf();
            c = (($urandom % 5) == 0) ? int'($urandom % 16) : int'(1 + $urandom % 8);
            run_job(c, int'($urandom % 8), int'($urandom % 8), 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
